dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the core MEM stage and port 1 is a debug/DMA master.
- The block sits between both requesters and the dmem macro. It drives the macro's enable, write, address, write-data and strobe signals.
- One transaction is outstanding at a time. The memory read latency is a fixed parameter.
- Out-of-range addresses are rejected with an error response and never reach memory.

Parameters:
- MemLatency, 1, cycles from the mem_en_o cycle to valid mem_rdata_i; range 1..15.
- MemBytes, 4096, size of the addressable window; an address >= MemBytes is an error.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  2  per-port request; held until the matching gnt_o.
- we_i  in  2  per-port write enable.
- addr_i  in  2x32  per-port byte address.
- wdata_i  in  2x32  per-port write data.
- wstrb_i  in  2x4  per-port byte strobes.
- gnt_o  out  2  one-hot, combinational grant pulse.
- rvalid_o  out  2  one-hot, registered response pulse.
- rdata_o  out  32  registered read data; 0 for writes and errors.
- err_o  out  1  registered; qualifies the rvalid_o pulse.
- mem_en_o  out  1  combinational memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_wstrb_o  out  4  memory byte strobes.
- mem_rdata_i  in  32  memory read data.
- busy_o  out  1  1 when the FSM is not IDLE.

Behaviour:
- Reset (async, any time):
  - state=IDLE, cnt=0, last_grant=1, rvalid_o=0, rdata_o=0, err_o=0.
  - gnt_o=0 and mem_en_o=0 while rst_i=1, whatever req_i is.
  - A response in flight is dropped and never delivered.
- FSM states: IDLE, WAIT.
- IDLE:
  - If any req_i bit is set, pick a winner w, assert gnt_o[w] in that cycle (cycle T), latch w, we, addr and an err flag, and go to WAIT with cnt=0.
  - In the same cycle, mem_en_o=1 and mem_* carry the port-w payload, unless addr >= MemBytes; then mem_en_o=0.
  - When mem_en_o=0, mem_* outputs are 0.
- WAIT:
  - cnt increments each cycle.
  - When cnt==MemLatency-1 (cycle T+MemLatency): capture mem_rdata_i only if it was a read and not an error, else capture 0. Go to IDLE.
  - The next cycle, T+MemLatency+1, has rvalid_o[w]=1 and err_o=flag for exactly one cycle.
- Back-to-back: a new grant may occur in the same cycle as rvalid_o. Peak throughput is one transaction per MemLatency+1 cycles.
- Arbitration:
  - Simultaneous requests are resolved by the selected policy (see Optional Feature).
  - last_grant updates on every grant.
- A requester dropping req_i before its grant is legal; it simply loses the request.
- The error path uses the same latency as a memory access, so response timing does not depend on the address.
- Widths: cnt is 4 bits. Address compare is unsigned 32-bit.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin. On a tie, the port != last_grant wins. last_grant resets to 1, so port 0 wins the first tie.
- Undefined: fixed priority. Port 0 always wins a tie. last_grant still updates but has no effect on arbitration.

Decomposition:
- custom_pkg holds:
  - typedef enum arb_state_e {IDLE, WAIT};
  - localparam ArbPorts=2;
  - typedef struct mem_req_t {we, addr, wdata, wstrb}.
- Sub-module dmem_arb_pick: combinational winner select. Inputs are req, last_grant and the policy; output is a one-hot grant.
- The arbiter FSM, counter and response registers stay in dmem_arbiter.

Test Plan:
- Single read, MemLatency=1: port0 reads addr 0x10 at T with memory returning 0xDEADBEEF → gnt_o=01 at T, mem_en_o=1 at T, rvalid_o=01 with rdata_o=0xDEADBEEF and err_o=0 at T+2.
- Tie with DMEM_ARB_RR_EN: both ports hold req continuously → grants alternate 01, 10, 01 every 2 cycles. Without the macro → 01 is granted every time.
- Error: port1 writes addr 0x1000 (= MemBytes) → gnt_o=10, mem_en_o=0, rvalid_o=10 at T+2 with err_o=1 and rdata_o=0.
- MemLatency=3: port0 reads → busy_o=1 for cycles T+1..T+3, rvalid_o at T+4; a port1 request held from T+1 is granted at T+4.
- Reset mid-WAIT: assert rst_i at T+1 → busy_o=0 immediately, no rvalid_o, and the next request is granted normally after release.
- Write with wstrb_i=4'b0011, wdata=0x12345678 → mem_we_o=1 and mem_wstrb_o=0011 at T; rvalid_o at T+2 with rdata_o=0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter.
// Holds the FSM state enum, the port count and the memory request payload struct.
package dmem_arbiter_pkg;

    localparam int unsigned ArbPorts = 2;
    localparam int unsigned AddrW    = 32;
    localparam int unsigned DataW    = 32;
    localparam int unsigned StrbW    = 4;
    localparam int unsigned CntW     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             we;
        logic [AddrW-1:0] addr;
        logic [DataW-1:0] wdata;
        logic [StrbW-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the two-port dmem arbiter.
// Ports:
//   req_i        per-port request vector
//   last_grant_i index of the most recently granted port
//   rr_en_i      1 = round-robin on a tie, 0 = port 0 always wins a tie
//   gnt_o        one-hot winner (all zero when nothing is requested)
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic [ArbPorts-1:0] req_i,
    input  logic                last_grant_i,
    input  logic                rr_en_i,
    output logic [ArbPorts-1:0] gnt_o
);

    // On a tie the port that was not granted last wins under round-robin.
    always_comb begin
        gnt_o = '0;
        if (req_i == 2'b11) begin
            if (rr_en_i && !last_grant_i) begin
                gnt_o = 2'b10;
            end else begin
                gnt_o = 2'b01;
            end
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core MEM stage (port 0) and a
// debug/DMA master (port 1). One transaction outstanding at a time, fixed
// read latency, out-of-range addresses answered with an error and never
// forwarded to memory.
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking;
// otherwise port 0 has fixed priority.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   req_i/we_i/addr_i/
//   wdata_i/wstrb_i          per-port request payload
//   gnt_o                    combinational one-hot grant pulse
//   rvalid_o/rdata_o/err_o   registered response
//   mem_*_o / mem_rdata_i    memory macro interface (mem_* combinational)
//   busy_o                   transaction in flight
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MemLatency = 1,
    parameter int unsigned MemBytes   = 4096
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [ArbPorts-1:0]            req_i,
    input  logic [ArbPorts-1:0]            we_i,
    input  logic [ArbPorts-1:0][AddrW-1:0] addr_i,
    input  logic [ArbPorts-1:0][DataW-1:0] wdata_i,
    input  logic [ArbPorts-1:0][StrbW-1:0] wstrb_i,
    output logic [ArbPorts-1:0]            gnt_o,
    output logic [ArbPorts-1:0]            rvalid_o,
    output logic [DataW-1:0]               rdata_o,
    output logic                           err_o,
    output logic                           mem_en_o,
    output logic                           mem_we_o,
    output logic [AddrW-1:0]               mem_addr_o,
    output logic [DataW-1:0]               mem_wdata_o,
    output logic [StrbW-1:0]               mem_wstrb_o,
    input  logic [DataW-1:0]               mem_rdata_i,
    output logic                           busy_o
);

`ifdef DMEM_ARB_RR_EN
    localparam logic RrEn = 1'b1;
`else
    localparam logic RrEn = 1'b0;
`endif

    arb_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  win_q, win_d;
    logic                  we_q, we_d;
    logic                  err_flag_q, err_flag_d;
    logic [ArbPorts-1:0]   rvalid_q, rvalid_d;
    logic [DataW-1:0]      rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [ArbPorts-1:0]   pick_gnt;
    logic                  win_c;
    logic                  grant_c;
    logic                  last_beat_c;
    logic                  sel_err_c;
    mem_req_t              sel_req;

    dmem_arb_pick u_pick (
        .req_i        (req_i),
        .last_grant_i (last_grant_q),
        .rr_en_i      (RrEn),
        .gnt_o        (pick_gnt)
    );

    // Winner payload and range check; the grant is suppressed while in reset.
    always_comb begin
        win_c         = pick_gnt[1];
        grant_c       = (state_q == IDLE) && (|req_i) && !rst_i;
        last_beat_c   = (state_q == WAIT) && (cnt_q == CntW'(MemLatency - 1));
        sel_req.we    = we_i[win_c];
        sel_req.addr  = addr_i[win_c];
        sel_req.wdata = wdata_i[win_c];
        sel_req.wstrb = wstrb_i[win_c];
        sel_err_c     = sel_req.addr >= AddrW'(MemBytes);
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_c)     state_d = WAIT;
            WAIT:    if (last_beat_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant and memory-side outputs; mem_* stay zero unless the access is issued.
    always_comb begin
        gnt_o       = '0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        if (grant_c) begin
            gnt_o = pick_gnt;
            if (!sel_err_c) begin
                mem_en_o    = 1'b1;
                mem_we_o    = sel_req.we;
                mem_addr_o  = sel_req.addr;
                mem_wdata_o = sel_req.wdata;
                mem_wstrb_o = sel_req.wstrb;
            end
        end
        busy_o = (state_q != IDLE);
    end

    // Transaction bookkeeping and response capture; errors reuse the memory latency.
    always_comb begin
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        we_d         = we_q;
        err_flag_d   = err_flag_q;
        rvalid_d     = '0;
        rdata_d      = '0;
        err_d        = 1'b0;
        if (grant_c) begin
            cnt_d        = '0;
            last_grant_d = win_c;
            win_d        = win_c;
            we_d         = sel_req.we;
            err_flag_d   = sel_err_c;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + CntW'(1);
            if (last_beat_c) begin
                rvalid_d = win_q ? 2'b10 : 2'b01;
                rdata_d  = (!we_q && !err_flag_q) ? mem_rdata_i : '0;
                err_d    = err_flag_q;
            end
        end
    end

    // Datapath and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            err_flag_q   <= 1'b0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            we_q         <= we_d;
            err_flag_q   <= err_flag_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule
